// File: rtl/stream_frame_aligner.sv
// Frame aligner: buffers an 8-bit sample stream and re-emits it as fixed
// FRAME_LEN-beat frames, zero-padding short frames and truncating long ones.
`timescale 1ns/1ps
module stream_frame_aligner #(
    parameter int DATA_W     = 8,
    parameter int FRAME_LEN  = 256,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic [15:0]       short_cnt,
    output logic [15:0]       long_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

    localparam logic [1:0] ST_PASS = 2'd0;
    localparam logic [1:0] ST_PAD  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    // Small buffer: kept as an asynchronously read array so the head entry
    // is visible in the cycle right after it is written.
    logic [DATA_W:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]  wr_ptr_reg, rd_ptr_reg;
    logic            full, empty, push, pop;
    logic [DATA_W:0] head;
    logic            head_last;
    logic [DATA_W-1:0] head_data;

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [15:0]      short_cnt_reg, short_cnt_next;
    logic [15:0]      long_cnt_reg, long_cnt_next;
    logic             short_inc, long_inc;
    logic             out_valid, out_last;
    logic [DATA_W-1:0] out_data;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                   (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

    assign s_ready   = !full && !wb_rst_i;
    assign push      = s_valid && s_ready;
    assign head      = mem[rd_ptr_reg[PTR_W-1:0]];
    assign head_last = head[DATA_W];
    assign head_data = head[DATA_W-1:0];

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr_reg[PTR_W-1:0]] <= {s_last, s_data};
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pop        = 1'b0;
        short_inc  = 1'b0;
        long_inc   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        case (state_reg)
            ST_PASS: begin
                out_valid = !empty;
                out_data  = head_data;
                out_last  = (cnt_reg == LAST_BEAT);
                if (!empty && m_ready) begin
                    pop = 1'b1;
                    if (cnt_reg == LAST_BEAT) begin
                        cnt_next = '0;
                        if (!head_last) begin
                            state_next = ST_DROP;
                            long_inc   = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                        if (head_last) begin
                            state_next = ST_PAD;
                            short_inc  = 1'b1;
                        end
                    end
                end
            end
            ST_PAD: begin
                out_valid = 1'b1;
                out_last  = (cnt_reg == LAST_BEAT);
                if (m_ready) begin
                    if (cnt_reg == LAST_BEAT) begin
                        cnt_next   = '0;
                        state_next = ST_PASS;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            ST_DROP: begin
                // Discard the tail of a truncated frame up to its end marker.
                pop = !empty;
                if (!empty && head_last) begin
                    state_next = ST_PASS;
                end
            end
            default: begin
                state_next = ST_PASS;
                cnt_next   = '0;
            end
        endcase
    end

    assign short_cnt_next = (short_inc && short_cnt_reg != 16'hFFFF) ?
                            short_cnt_reg + 16'd1 : short_cnt_reg;
    assign long_cnt_next  = (long_inc && long_cnt_reg != 16'hFFFF) ?
                            long_cnt_reg + 16'd1 : long_cnt_reg;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            state_reg     <= ST_PASS;
            cnt_reg       <= '0;
            short_cnt_reg <= '0;
            long_cnt_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            short_cnt_reg <= short_cnt_next;
            long_cnt_reg  <= long_cnt_next;
        end
    end

    // Outputs are forced idle while reset is held, even before the flush edge.
    assign m_valid   = out_valid && !wb_rst_i;
    assign m_data    = wb_rst_i ? '0 : out_data;
    assign m_last    = out_last && !wb_rst_i;
    assign short_cnt = short_cnt_reg;
    assign long_cnt  = long_cnt_reg;

endmodule

// File: tb/tb_stream_frame_aligner.sv
// Randomized bench for stream_frame_aligner with a frame-level scoreboard
// (expected beats derived from frame lengths) plus directed corner cases.
`timescale 1ns/1ps
module tb_stream_frame_aligner;

    localparam int DW = 8;
    localparam int FL = 8;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready = 1'b0;
    logic [15:0]   short_cnt, long_cnt;

    stream_frame_aligner #(.DATA_W(DW), .FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .short_cnt(short_cnt),
        .long_cnt (long_cnt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [8:0]  exp_q[$];
    int          pos      = 0;
    logic [15:0] exp_short = 16'd0;
    logic [15:0] exp_long  = 16'd0;
    int          beats    = 0;
    int          accepted = 0;
    int          rdy_mode = 0;
    logic        hold_prev = 1'b0;
    logic [7:0]  prev_data;
    logic        prev_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: every frame becomes exactly FL beats; extra samples vanish.
    task automatic model_push(input logic [7:0] d, input logic l);
        pos++;
        accepted++;
        if (pos <= FL) exp_q.push_back({pos == FL, d});
        if (l) begin
            if (pos < FL) begin
                for (int k = pos + 1; k <= FL; k++) exp_q.push_back({k == FL, 8'h00});
                if (exp_short != 16'hFFFF) exp_short++;
            end else if (pos > FL) begin
                if (exp_long != 16'hFFFF) exp_long++;
            end
            pos = 0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pos       = 0;
        exp_short = 16'd0;
        exp_long  = 16'd0;
    endtask

    task automatic push_sample(input logic [7:0] d, input logic l);
        bit got = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (s_ready) begin
                model_push(d, l);
                got = 1;
            end
            @(posedge clk); #1;
            if (got) break;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!got) check("push_timeout", 0, 1);
    endtask

    task automatic push_frame(input logic [7:0] base, input int len, input bit rnd);
        for (int i = 0; i < len; i++) begin
            if (rnd) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            push_sample(rnd ? 8'($urandom) : 8'(base + i), i == len - 1);
        end
    endtask

    task automatic drain();
        int t = 0;
        rdy_mode = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain_done", exp_q.size(), 0);
        repeat (10) @(posedge clk);
        #1;
        check("short_cnt", short_cnt, exp_short);
        check("long_cnt", long_cnt, exp_long);
    endtask

    initial begin
        forever begin
            @(posedge clk); #2;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: scoreboard compare on each handshake, stability under stall.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check("hold_valid", m_valid, 1);
                    check("hold_data", m_data, prev_data);
                    check("hold_last", m_last, prev_last);
                end
                hold_prev = m_valid && !m_ready;
                prev_data = m_data;
                prev_last = m_last;
                if (m_valid && m_ready) begin
                    beats++;
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", m_data, e[7:0]);
                        check("beat_last", m_last, e[8]);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, b0;
        rdy_mode = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_data", m_data, 0);
        check("rst_short", short_cnt, 0);
        check("rst_long", long_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("s_ready_after_rst", s_ready, 1);
        @(posedge clk); #1;

        // Exact-length frame with one-cycle latency check on the first sample.
        push_sample(8'h01, 1'b0);
        @(negedge clk);
        check("latency_valid", m_valid, 1);
        check("latency_data", m_data, 8'h01);
        @(posedge clk); #1;
        for (int i = 2; i <= 8; i++) push_sample(8'(i), i == 8);
        drain();

        push_frame(8'h11, 5, 0);
        drain();
        push_frame(8'h21, 11, 0);
        drain();
        push_frame(8'h61, 8, 0);
        drain();

        // Backpressure: FIFO fills at 4 entries and head stays put.
        rdy_mode = 2;
        @(posedge clk); #1;
        a0 = accepted;
        fork
            push_frame(8'h51, 6, 0);
            begin
                for (int t = 0; t < 100; t++) begin
                    @(negedge clk);
                    if (accepted - a0 >= 4) break;
                end
                @(negedge clk);
                check("bp_accepted", accepted - a0, 4);
                check("bp_s_ready", s_ready, 0);
                check("bp_m_valid", m_valid, 1);
                check("bp_m_data", m_data, 8'h51);
                repeat (3) @(negedge clk);
                check("bp_still_full", accepted - a0, 4);
                check("bp_s_ready_held", s_ready, 0);
                @(posedge clk); #1;
                rdy_mode = 0;
            end
        join
        drain();

        // Reset in the middle of a frame.
        rdy_mode = 2;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) push_sample(8'(8'h31 + i), 1'b0);
        b0 = beats;
        rdy_mode = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (beats - b0 >= 3) break;
        end
        check("mid_beats", (beats - b0 >= 3) ? 1 : 0, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_s_ready", s_ready, 0);
        check("mid_rst_m_last", m_last, 0);
        check("mid_rst_m_data", m_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", s_ready, 1);
        check("post_rst_m_valid", m_valid, 0);
        @(posedge clk); #1;
        push_frame(8'h41, 8, 0);
        drain();

        // Random frame lengths, random gaps, random backpressure.
        rdy_mode = 1;
        for (int f = 0; f < 40; f++) push_frame(8'h00, $urandom_range(1, 12), 1);
        drain();

        // Saturation: preload the short counter near its ceiling.
        force dut.short_cnt_reg = 16'hFFFE;
        exp_short = 16'hFFFE;
        @(negedge clk);
        @(posedge clk); #1;
        release dut.short_cnt_reg;
        @(negedge clk);
        check("short_preload", short_cnt, 16'hFFFE);
        @(posedge clk); #1;
        for (int f = 0; f < 3; f++) begin
            push_frame(8'h70, 3, 0);
            drain();
        end
        check("short_saturated", short_cnt, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
